// File: rtl/ser_slot_arbiter.sv
// Byte-slot scheduler ahead of the 8-bit serializer: one byte (data or fill) per 8-cycle slot,
// granted round-robin across requesters with bursts capped at MAX_BURST bytes.

module ser_slot_lane #(
    parameter logic [1:0] LANE = 2'd0
) (
    input  logic [1:0] grant,
    input  logic       busy,
    input  logic       slot_five,
    output logic       ready
);
    // Decoded from registered state only, so it never loops back through req_valid.
    assign ready = busy && slot_five && (grant == LANE);
endmodule

module ser_slot_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         MAX_BURST = 4,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic                 clock_ser,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           ser_data,
    output logic                 ser_enable,
    output logic                 idle_fill,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 slot_tick
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          state_q, state_d;
    logic [2:0]      slot_cnt;
    logic [1:0]      grant;
    logic [1:0]      last_grant;
    logic [3:0]      burst_cnt;

    logic [3:0]      vld_pad;
    logic [3:0][7:0] data_pad;
    logic            arb_run;
    logic            arb_found;
    logic [1:0]      arb_idx;
    logic [1:0]      cand;
    logic            slot_four;
    logic            slot_five;
    logic            xfer;

    assign slot_four = (slot_cnt == 3'd4);
    assign slot_five = (slot_cnt == 3'd5);

    // Pad requester inputs to 4 lanes so 2-bit grant indices stay in range for any N_REQ.
    always_comb begin
        vld_pad  = '0;
        data_pad = '0;
        for (int i = 0; i < N_REQ; i++) begin
            vld_pad[i]  = req_valid[i];
            data_pad[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin search starting one past the last winner, wrapping at N_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant;
        cand      = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == 2'(N_REQ - 1)) ? 2'd0 : cand + 2'd1;
            if (!arb_found && vld_pad[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign arb_run = (state_q == S_IDLE) || (burst_cnt == 4'(MAX_BURST));
    assign xfer    = (state_q == S_BURST) && slot_five && vld_pad[grant];

    // FSM: state register
    always_ff @(posedge clock_ser or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (slot_four && arb_run)
            state_d = arb_found ? S_BURST : S_IDLE;
        else if (slot_five && (state_q == S_BURST) && !vld_pad[grant])
            state_d = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q == S_BURST);
        slot_tick = (slot_cnt == 3'd7);
        grant_id  = grant;
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        ser_slot_lane #(.LANE(2'(i))) u_lane (
            .grant     (grant),
            .busy      (busy),
            .slot_five (slot_five),
            .ready     (req_ready[i])
        );
    end

    // Slot timing, grant bookkeeping and the serializer load register.
    always_ff @(posedge clock_ser or negedge reset) begin
        if (!reset) begin
            slot_cnt   <= 3'd0;
            grant      <= 2'd0;
            last_grant <= 2'(N_REQ - 1);
            burst_cnt  <= 4'd0;
            ser_data   <= IDLE_BYTE;
            ser_enable <= 1'b0;
            idle_fill  <= 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 3'd1;
            if (slot_four && arb_run && arb_found) begin
                grant      <= arb_idx;
                last_grant <= arb_idx;
                burst_cnt  <= 4'd0;
            end
            if (slot_five) begin
                ser_enable <= 1'b1;
                if (xfer) begin
                    ser_data  <= data_pad[grant];
                    idle_fill <= 1'b0;
                    burst_cnt <= burst_cnt + 4'd1;
                end else begin
                    ser_data  <= IDLE_BYTE;
                    idle_fill <= 1'b1;
                end
            end else if (slot_cnt == 3'd6) begin
                ser_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ser_slot_arbiter.sv
// Scoreboard bench: stimulus pushes the expected byte for each slot, the monitor pops on every serializer load.

module tb_ser_slot_arbiter;

    logic        clock_ser = 1'b0;
    logic        reset     = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic [7:0]  ser_data;
    logic        ser_enable;
    logic        idle_fill;
    logic [1:0]  grant_id;
    logic        busy;
    logic        slot_tick;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    ser_slot_arbiter #(.N_REQ(4), .MAX_BURST(4), .IDLE_BYTE(8'h00)) dut (
        .clock_ser  (clock_ser),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .ser_data   (ser_data),
        .ser_enable (ser_enable),
        .idle_fill  (idle_fill),
        .grant_id   (grant_id),
        .busy       (busy),
        .slot_tick  (slot_tick)
    );

    always #5 clock_ser = ~clock_ser;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every serializer load must match the next queued expectation.
    always @(negedge clock_ser) begin
        if (reset === 1'b1 && ser_enable !== 1'b0) begin
            if (sb.size() == 0) begin
                check("load_expected", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ser_data", 32'(ser_data), 32'(e.d));
                check("idle_fill", 32'(idle_fill), 32'(e.f));
            end
        end
    end

    // Entered mid cycle 0 of a slot; leaves mid cycle 0 of the next slot.
    task automatic run_slot(input logic [7:0] d, input logic f, input logic [3:0] rdy,
                            input logic bsy, input logic [1:0] gid, input logic [3:0] drop);
        sb.push_back(exp_t'({d, f}));
        repeat (5) @(negedge clock_ser);
        check("req_ready_c5", 32'(req_ready), 32'(rdy));
        check("busy_c5", 32'(busy), 32'(bsy));
        check("grant_id_c5", 32'(grant_id), 32'(gid));
        check("slot_tick_c5", 32'(slot_tick), 32'd0);
        @(negedge clock_ser);
        req_valid = req_valid & ~drop;
        @(negedge clock_ser);
        check("slot_tick_c7", 32'(slot_tick), 32'd1);
        @(negedge clock_ser);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles, all outputs at reset values.
        repeat (3) @(negedge clock_ser);
        check("rst_ser_data", 32'(ser_data), 32'h00);
        check("rst_ser_enable", 32'(ser_enable), 32'd0);
        check("rst_idle_fill", 32'(idle_fill), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_slot_tick", 32'(slot_tick), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b1;

        // Idle fill slots.
        repeat (2) run_slot(8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000);

        // Round-robin: all valid, each sends its index, bursts of 4, no fill.
        req_data  = {8'h03, 8'h02, 8'h01, 8'h00};
        req_valid = 4'b1111;
        for (int g = 0; g < 20; g++) begin
            int r;
            r = (g / 4) % 4;
            run_slot(8'(r), 1'b0, 4'(1 << r), 1'b1, 2'(r), 4'b0000);
        end
        req_valid = 4'b0000;
        run_slot(8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000);

        // Single requester 1 with one byte, then the burst ends on the empty slot.
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        run_slot(8'hA5, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0010);
        run_slot(8'h00, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0000);
        run_slot(8'h00, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000);

        // Early burst end: requester 2 sends two bytes and drops; requester 3 follows.
        req_data[23:16] = 8'h21;
        req_valid       = 4'b0100;
        run_slot(8'h21, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000);
        req_data[23:16] = 8'h22;
        req_data[31:24] = 8'h3C;
        req_valid       = 4'b1100;
        run_slot(8'h22, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0100);
        run_slot(8'h00, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0000);
        run_slot(8'h3C, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b1000);
        run_slot(8'h00, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b0000);
        run_slot(8'h00, 1'b1, 4'b0000, 1'b0, 2'd3, 4'b0000);

        // Sole requester 0: re-granted across burst expiry with no fill slot.
        req_valid = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            req_data[7:0] = 8'h50 + 8'(k);
            run_slot(8'h50 + 8'(k), 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000);
        end

        // Reset while req_ready is high in cycle 5: byte discarded, outputs clear at once.
        req_data[7:0] = 8'h60;
        repeat (5) @(negedge clock_ser);
        check("pre_rst_req_ready", 32'(req_ready), 32'b0001);
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_ser_enable", 32'(ser_enable), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_idle_fill", 32'(idle_fill), 32'd1);
        check("midrst_ser_data", 32'(ser_data), 32'h00);
        req_data[7:0] = 8'h77;
        repeat (2) @(negedge clock_ser);
        reset = 1'b1;
        run_slot(8'h77, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0001);
        run_slot(8'h00, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
